// File: rtl/serial_mag_comp_ctrl_if.sv
// Handshake and operand/result bundle for serial_mag_comp_ctrl.
// master: the requester driving start/a/b; slave: the comparator sequencer.
interface serial_mag_comp_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             G;
    logic             L;
    logic             E;

    modport master (
        output start, a, b,
        input  busy, done, G, L, E
    );

    modport slave (
        input  start, a, b,
        output busy, done, G, L, E
    );
endinterface

// File: rtl/serial_mag_comp_ctrl.sv
// Serial unsigned magnitude comparator: steps a 2-bit G/L/E compare slice over
// the operands one digit per cycle, most significant digit first.
// Optional build macro SERIAL_COMP_EARLY_EXIT_EN: finish on the first unequal
// digit instead of always walking all WIDTH/2 digits.
module serial_mag_comp_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_mag_comp_ctrl_if.slave bus
);
    localparam int unsigned D    = WIDTH / 2;
    localparam int unsigned CntW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             pend_dec_q, pend_dec_d;  // an unequal digit has been seen
    logic             pend_g_q, pend_g_d;      // direction of that first unequal digit
    logic             done_q, done_d;
    logic             g_q, g_d;
    logic             l_q, l_d;
    logic             e_q, e_d;

    logic [1:0]       digit_a;
    logic [1:0]       digit_b;
    logic             slice_g;
    logic             slice_l;
    logic             dec_now;
    logic             g_now;
    logic             last;

    // 2-bit compare slice on the current top digit, merged with the pending result
    always_comb begin
        digit_a = sa_q[WIDTH-1 -: 2];
        digit_b = sb_q[WIDTH-1 -: 2];
        slice_g = digit_a > digit_b;
        slice_l = digit_a < digit_b;
        // The first unequal digit decides; later digits cannot override it.
        dec_now = pend_dec_q | slice_g | slice_l;
        g_now   = pend_dec_q ? pend_g_q : slice_g;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
        last    = (cnt_q == '0) | dec_now;
`else
        last    = (cnt_q == '0);
`endif
    end

    // Next-state and datapath updates for the IDLE/RUN sequencer
    always_comb begin
        state_d    = state_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        cnt_d      = cnt_q;
        pend_dec_d = pend_dec_q;
        pend_g_d   = pend_g_q;
        done_d     = 1'b0;
        g_d        = g_q;
        l_d        = l_q;
        e_d        = e_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sa_d       = bus.a;
                    sb_d       = bus.b;
                    cnt_d      = CntW'(D - 1);
                    pend_dec_d = 1'b0;
                    pend_g_d   = 1'b0;
                    state_d    = StRun;
                end
            end
            StRun: begin
                pend_dec_d = dec_now;
                pend_g_d   = g_now;
                sa_d       = sa_q << 2;
                sb_d       = sb_q << 2;
                cnt_d      = cnt_q - CntW'(1);
                if (last) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    g_d     = dec_now & g_now;
                    l_d     = dec_now & ~g_now;
                    e_d     = ~dec_now;
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sa_q       <= '0;
            sb_q       <= '0;
            cnt_q      <= '0;
            pend_dec_q <= 1'b0;
            pend_g_q   <= 1'b0;
            done_q     <= 1'b0;
            g_q        <= 1'b0;
            l_q        <= 1'b0;
            e_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            cnt_q      <= cnt_d;
            pend_dec_q <= pend_dec_d;
            pend_g_q   <= pend_g_d;
            done_q     <= done_d;
            g_q        <= g_d;
            l_q        <= l_d;
            e_q        <= e_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = done_q;
    assign bus.G    = g_q;
    assign bus.L    = l_q;
    assign bus.E    = e_q;
endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Self-checking bench for serial_mag_comp_ctrl (WIDTH=8). Expected G/L/E and
// completion cycle are queued at launch and checked when done pulses.
module tb_serial_mag_comp_ctrl;
    localparam int unsigned WIDTH = 8;
    localparam int          D     = WIDTH / 2;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       g;
        logic       l;
        logic       e;
        int         j;  // 1-based position of first differing digit (D if equal)
    } vec_t;

    typedef struct {
        logic g;
        logic l;
        logic e;
        int   due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    exp_t ent;
    vec_t vecs[10];

    serial_mag_comp_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_mag_comp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int j);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
        return j;
`else
        return D;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Completion monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_done: got done=1 at cycle %0d expected no completion", cyc);
            end else begin
                ent = sb_q.pop_front();
                check("result_G", bus.G, ent.g);
                check("result_L", bus.L, ent.l);
                check("result_E", bus.E, ent.e);
                check("done_cycle", cyc, ent.due);
                check("busy_at_done", bus.busy, 1'b0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("wait_idle_timeout", 1, 0);
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b,
                          input logic g, input logic l, input logic e, input int j);
        wait_idle();
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        sb_q.push_back('{g: g, l: l, e: e, due: cyc + lat(j)});
        check("busy_after_start", bus.busy, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        vecs[0] = '{a: 8'hB4, b: 8'hB4, g: 1'b0, l: 1'b0, e: 1'b1, j: 4};
        vecs[1] = '{a: 8'hC0, b: 8'h80, g: 1'b1, l: 1'b0, e: 1'b0, j: 1};
        vecs[2] = '{a: 8'h12, b: 8'h13, g: 1'b0, l: 1'b1, e: 1'b0, j: 4};
        vecs[3] = '{a: 8'h00, b: 8'hFF, g: 1'b0, l: 1'b1, e: 1'b0, j: 1};
        vecs[4] = '{a: 8'h9C, b: 8'h98, g: 1'b1, l: 1'b0, e: 1'b0, j: 3};
        vecs[5] = '{a: 8'h37, b: 8'h27, g: 1'b1, l: 1'b0, e: 1'b0, j: 2};
        vecs[6] = '{a: 8'hFF, b: 8'hFF, g: 1'b0, l: 1'b0, e: 1'b1, j: 4};
        vecs[7] = '{a: 8'h21, b: 8'h12, g: 1'b1, l: 1'b0, e: 1'b0, j: 2};
        vecs[8] = '{a: 8'h7F, b: 8'h80, g: 1'b0, l: 1'b1, e: 1'b0, j: 1};
        vecs[9] = '{a: 8'h13, b: 8'h12, g: 1'b1, l: 1'b0, e: 1'b0, j: 4};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_G", bus.G, 1'b0);
        check("reset_L", bus.L, 1'b0);
        check("reset_E", bus.E, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].l, vecs[i].e, vecs[i].j);
            drain();
        end

        // Start pulsed while busy is ignored; start held through done is taken at once.
        launch(8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 4);
        @(posedge clk);
        #1;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("hold_G_while_busy", bus.G, vecs[9].g);
        check("hold_L_while_busy", bus.L, vecs[9].l);
        bus.a     = 8'h01;
        bus.b     = 8'h02;
        bus.start = 1'b1;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) check("b2b_done_timeout", 1, 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_busy", bus.busy, 1'b1);
        sb_q.push_back('{g: 1'b0, l: 1'b1, e: 1'b0, due: cyc + lat(4)});
        drain();

        // Reset in the middle of a comparison: no done, outputs cleared.
        wait_idle();
        bus.a     = 8'h40;
        bus.b     = 8'h41;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        check("midrst_G", bus.G, 1'b0);
        check("midrst_L", bus.L, 1'b0);
        check("midrst_E", bus.E, 1'b0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_still_idle", bus.busy, 1'b0);
        launch(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 4);
        drain();

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
